// File: rtl/int4_dequant_feeder.sv
// rtl/int4_dequant_feeder.sv - sequences FP16 group scales and int4 weight nibbles into operand pairs
// One scale covers GROUP_SIZE weights; each packed word is emitted lane 0 first.
module int4_dequant_feeder #(
  parameter int INT_WIDTH  = 4,
  parameter int WORD_WIDTH = 32,
  parameter int FP_WIDTH   = 16,
  parameter int GROUP_SIZE = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  num_weights_i,
  input  logic                  scale_valid_i,
  output logic                  scale_ready_o,
  input  logic [FP_WIDTH-1:0]   scale_data_i,
  input  logic                  weight_valid_i,
  output logic                  weight_ready_o,
  input  logic [WORD_WIDTH-1:0] weight_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [FP_WIDTH-1:0]   out_a_o,
  output logic [INT_WIDTH-1:0]  out_b_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LANES  = WORD_WIDTH / INT_WIDTH;
  localparam int LANE_W = $clog2(LANES);
  localparam int GRP_W  = $clog2(GROUP_SIZE);

  localparam logic [LANE_W-1:0]    LANE_ONE  = {{(LANE_W-1){1'b0}}, 1'b1};
  localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [GRP_W-1:0]     GRP_ONE   = {{(GRP_W-1){1'b0}}, 1'b1};
  localparam logic [GRP_W-1:0]     GRP_LAST  = GRP_W'(GROUP_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] REM_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD_SCALE, LOAD_WORD, EMIT} state_t;

  state_t                state_q;
  logic [FP_WIDTH-1:0]   scale_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic [LANE_W-1:0]     lane_q;
  logic [GRP_W-1:0]      grp_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic                  done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      scale_q <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      grp_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_weights_i != '0) begin
              rem_q   <= num_weights_i;
              state_q <= LOAD_SCALE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        LOAD_SCALE: begin
          if (scale_valid_i) begin
            scale_q <= scale_data_i;
            grp_q   <= '0;
            state_q <= LOAD_WORD;
          end
        end
        LOAD_WORD: begin
          if (weight_valid_i) begin
            word_q  <= weight_data_i;
            lane_q  <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            rem_q  <= rem_q - REM_ONE;
            lane_q <= lane_q + LANE_ONE;
            grp_q  <= grp_q + GRP_ONE;
            // Group end always coincides with a word end, so the scale reload also fetches a word.
            if (rem_q == REM_ONE) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else if (grp_q == GRP_LAST) begin
              state_q <= LOAD_SCALE;
            end else if (lane_q == LANE_LAST) begin
              state_q <= LOAD_WORD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scale_ready_o  = (state_q == LOAD_SCALE);
  assign weight_ready_o = (state_q == LOAD_WORD);
  assign out_valid_o    = (state_q == EMIT);
  assign out_a_o        = out_valid_o ? scale_q : '0;
  assign out_b_o        = out_valid_o ? word_q[lane_q*INT_WIDTH +: INT_WIDTH] : '0;
  assign out_last_o     = out_valid_o && (rem_q == REM_ONE);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;

endmodule

// File: tb/tb_int4_dequant_feeder.sv
// tb/tb_int4_dequant_feeder.sv - directed table-driven bench for int4_dequant_feeder
// Inputs are driven and outputs sampled on the falling edge.
module tb_int4_dequant_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] num_weights_i;
  logic        scale_valid_i;
  logic        scale_ready_o;
  logic [15:0] scale_data_i;
  logic        weight_valid_i;
  logic        weight_ready_o;
  logic [31:0] weight_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_a_o;
  logic [3:0]  out_b_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] scales [0:3];
  logic [31:0] words  [0:15];

  always #5 clk_i = ~clk_i;

  int4_dequant_feeder dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_weights_i(num_weights_i),
    .scale_valid_i(scale_valid_i), .scale_ready_o(scale_ready_o), .scale_data_i(scale_data_i),
    .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_o), .weight_data_i(weight_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_a_o(out_a_o), .out_b_o(out_b_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int          num;
    logic [31:0] w0;
    bit          stall;
    bit          poke;
    int          exp_sx;
    int          exp_wx;
    logic [3:0]  exp_last_b;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " out_valid"}, {31'b0, out_valid_o}, 0);
    check({name, " readies"}, {30'b0, scale_ready_o, weight_ready_o}, 0);
    check({name, " out_a/b/last"}, {11'b0, out_a_o, out_b_o, out_last_o}, 0);
    check({name, " busy/done"}, {30'b0, busy_o, done_o}, 0);
  endtask

  task automatic run_job(input int num, input logic [31:0] w0, input bit stall, input bit poke,
                         input int abort_after, input int exp_sx, input int exp_wx,
                         input logic [3:0] exp_last_b);
    int sidx = 0, widx = 0, sx = 0, wx = 0, nbeats = 0;
    int first_sr = -1, first_ov = -1, last_cyc = -1, done_cyc = -1;
    bit prev_stall = 0, poked = 0, any_act = 0, aborted = 0;
    logic [15:0] pa; logic [3:0] pb; logic pl;
    logic [15:0] ga [$]; logic [3:0] gb [$]; logic gl [$];
    words[0] = w0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_i);
      start_i = (k == 0);
      num_weights_i = (k == 0) ? 16'(num) : 16'hFFFF;
      if (poke && nbeats == 3 && !poked) begin
        start_i = 1'b1;
        num_weights_i = 16'd3;
        poked = 1;
      end
      scale_valid_i  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      weight_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_i    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      scale_data_i   = scales[sidx % 4];
      weight_data_i  = words[widx % 16];
      if (prev_stall)
        check("stall hold", {11'b0, out_valid_o, out_a_o, out_b_o, out_last_o}, {11'b0, 1'b1, pa, pb, pl});
      if (k > 0 && (scale_ready_o || weight_ready_o || out_valid_o)) any_act = 1;
      if (k > 0 && scale_ready_o && first_sr < 0) first_sr = k;
      if (out_valid_o && first_ov < 0) first_ov = k;
      if (done_o) begin
        done_cyc = k;
        check("busy low with done", {31'b0, busy_o}, 0);
        break;
      end
      if (scale_valid_i && scale_ready_o) begin sx++; sidx++; end
      if (weight_valid_i && weight_ready_o) begin wx++; widx++; end
      if (out_valid_o && out_ready_i) begin
        ga.push_back(out_a_o); gb.push_back(out_b_o); gl.push_back(out_last_o);
        if (out_last_o) last_cyc = k;
        nbeats++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      pa = out_a_o; pb = out_b_o; pl = out_last_o;
      if (abort_after > 0 && nbeats == abort_after) begin aborted = 1; break; end
    end
    if (aborted) begin
      @(negedge clk_i);
      rst_i = 1'b1;
      start_i = 1'b0; scale_valid_i = 1'b0; weight_valid_i = 1'b0;
      #1 check_idle_outputs("reset mid-job");
      @(negedge clk_i);
      check_idle_outputs("reset held");
      rst_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("after reset");
      return;
    end
    check("job completes", {31'b0, done_cyc >= 0}, 1);
    check("beat count", nbeats, num);
    for (int i = 0; i < nbeats && i < num; i++) begin
      logic [31:0] w;
      w = words[i / 8];
      check($sformatf("beat %0d a", i), ga[i], scales[i / 32]);
      check($sformatf("beat %0d b", i), gb[i], (w >> (4 * (i % 8))) & 32'hF);
      check($sformatf("beat %0d last", i), {31'b0, gl[i]}, {31'b0, i == num - 1});
    end
    check("scale transfers", sx, exp_sx);
    check("weight transfers", wx, exp_wx);
    if (num == 0) begin
      check("zero-len done at t+1", done_cyc, 1);
      check("zero-len no handshakes", {31'b0, any_act}, 0);
    end else begin
      check("done after last", done_cyc, last_cyc + 1);
      check("last nibble", {28'b0, gb[nbeats-1]}, {28'b0, exp_last_b});
      if (!stall) begin
        check("scale ready at t+1", first_sr, 1);
        check("first valid at t+3", first_ov, 3);
      end
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16, 32'h76543210, 0, 0, 1, 2, 4'hF};
    vecs[1] = '{64, 32'h76543210, 0, 0, 2, 8, 4'h6};
    vecs[2] = '{64, 32'h76543210, 1, 0, 2, 8, 4'h6};
    vecs[3] = '{5,  32'h87654321, 0, 0, 1, 1, 4'h5};
    vecs[4] = '{40, 32'h76543210, 1, 1, 2, 5, 4'h5};
    vecs[5] = '{0,  32'h76543210, 0, 0, 0, 0, 4'h0};
    vecs[6] = '{16, 32'h76543210, 0, 1, 1, 2, 4'hF};

    scales[0] = 16'h3C00; scales[1] = 16'h4000; scales[2] = 16'h4200; scales[3] = 16'h4400;
    words[1] = 32'hFEDCBA98;
    for (int k = 2; k < 16; k++) words[k] = 32'h13579BDF ^ (k * 32'h11111111);

    rst_i = 1'b1; start_i = 1'b0; num_weights_i = '0;
    scale_valid_i = 1'b0; scale_data_i = '0; weight_valid_i = 1'b0; weight_data_i = '0;
    out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_idle_outputs("in reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("post reset");

    for (int v = 0; v < 7; v++)
      run_job(vecs[v].num, vecs[v].w0, vecs[v].stall, vecs[v].poke, 0,
              vecs[v].exp_sx, vecs[v].exp_wx, vecs[v].exp_last_b);

    run_job(16, 32'h76543210, 0, 0, 5, 0, 0, 4'h0);
    run_job(16, 32'h76543210, 0, 0, 0, 1, 2, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
